// File: rtl/mlp_cmd_pkg.sv
// rtl/mlp_cmd_pkg.sv - shared opcodes, FSM states and sizes for the MLP command loader
//
// Purpose: host opcode values, loader FSM state encoding, payload/result sizes
// and a small decode helper shared by mlp_cmd_loader and mlp_result_serializer.
// Ports: none (package).
package mlp_cmd_pkg;

  localparam logic [7:0] OP_LOAD_W  = 8'h01;
  localparam logic [7:0] OP_LOAD_A  = 8'h02;
  localparam logic [7:0] OP_START   = 8'h03;
  localparam logic [7:0] OP_WF_RST  = 8'h04;
  localparam logic [7:0] OP_CLR_ERR = 8'h05;

  localparam int RESULT_BYTES = 8;
  localparam int WGT_BYTES    = 4;

  typedef enum logic [2:0] {
    S_CMD,
    S_WGT,
    S_ACT,
    S_START,
    S_WAIT,
    S_SEND
  } state_t;

  // States in which the loader takes bytes from the host.
  function automatic logic state_accepts_rx(input state_t s);
    return (s == S_CMD) || (s == S_WGT) || (s == S_ACT);
  endfunction

endpackage

// File: rtl/mlp_result_serializer.sv
// rtl/mlp_result_serializer.sv - loads a 64-bit result and shifts it out as 8 bytes
//
// Purpose: on load, captures load_data and presents it LSB byte first on a
// valid/ready byte stream; tx_data is held while the receiver stalls.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   load                  capture load_data and start sending (ignored bytes in flight are replaced)
//   load_data  [63:0]     result word, byte 0 sent first
//   tx_valid / tx_ready   byte handshake
//   tx_data    [7:0]      current byte
//   last_xfer             high in the cycle the final byte is transferred
module mlp_result_serializer
  import mlp_cmd_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      load,
  input  logic [8*RESULT_BYTES-1:0] load_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [7:0]                tx_data,
  output logic                      last_xfer
);

  localparam int IDX_W = $clog2(RESULT_BYTES);

  logic [8*RESULT_BYTES-1:0] shreg;
  logic [IDX_W-1:0]          idx;

  // tx_data is a slice of the shift register, so it is a registered output.
  assign tx_data   = shreg[7:0];
  assign last_xfer = tx_valid && tx_ready && (idx == IDX_W'(RESULT_BYTES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg    <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= load_data;
      idx      <= '0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      shreg <= shreg >> 8;
      idx   <= idx + IDX_W'(1);
      if (last_xfer) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mlp_cmd_loader.sv
// rtl/mlp_cmd_loader.sv - byte-stream command sequencer feeding the MLP top level
//
// Purpose: decodes host opcodes from an 8-bit valid/ready stream, drives weight
// FIFO pushes/reset, initial activations and start_mlp, then returns acc0/acc1
// as 8 bytes once the layer completes.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   rx_valid, rx_ready, rx_data[7:0]   host command/payload bytes
//   tx_valid, tx_ready, tx_data[7:0]   result bytes (acc0 LSB first, then acc1)
//   wf_push_col0, wf_push_col1         weight FIFO push strobes
//   wf_data_out[7:0]                   weight byte
//   wf_reset                           weight FIFO clear strobe
//   init_act_valid, init_act_data[15:0] activation word strobe/data
//   start_mlp                          start pulse
//   weights_ready                      full weight set loaded
//   layer_complete, acc0, acc1         MLP completion flag and results
//   busy                               not idle in S_CMD
//   err_opcode, err_timeout            sticky error flags
module mlp_cmd_loader
  import mlp_cmd_pkg::*;
#(
  parameter int N_ACT_WORDS = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        wf_push_col0,
  output logic        wf_push_col1,
  output logic [7:0]  wf_data_out,
  output logic        wf_reset,
  output logic        init_act_valid,
  output logic [15:0] init_act_data,
  output logic        start_mlp,
  output logic        weights_ready,
  input  logic        layer_complete,
  input  logic [31:0] acc0,
  input  logic [31:0] acc1,
  output logic        busy,
  output logic        err_opcode,
  output logic        err_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam int CNT_W = $clog2(2 * N_ACT_WORDS) + 1;

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] WGT_LAST = CNT_W'(WGT_BYTES - 1);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(2 * N_ACT_WORDS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       act_lo_q, act_lo_d;
  logic             lc_q;

  logic        push0_d, push1_d, wf_reset_d, act_valid_d, start_d;
  logic        wready_d, err_op_d, err_to_d;
  logic [7:0]  wf_data_d;
  logic [15:0] act_data_d;
  logic        ser_load, ser_last;

  logic rx_fire;
  logic lc_rise;

  assign rx_fire = rx_valid && rx_ready;
  // lc_q follows layer_complete every cycle, so a level already high when
  // S_WAIT is entered never looks like a rising edge.
  assign lc_rise = layer_complete && !lc_q;

  mlp_result_serializer u_ser (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (ser_load),
    .load_data ({acc1, acc0}),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .last_xfer (ser_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CMD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    act_lo_d    = act_lo_q;
    push0_d     = 1'b0;
    push1_d     = 1'b0;
    wf_data_d   = wf_data_out;
    wf_reset_d  = 1'b0;
    act_valid_d = 1'b0;
    act_data_d  = init_act_data;
    start_d     = 1'b0;
    wready_d    = weights_ready;
    err_op_d    = err_opcode;
    err_to_d    = err_timeout;
    ser_load    = 1'b0;

    case (state_q)
      S_CMD: begin
        if (rx_fire) begin
          case (rx_data)
            OP_LOAD_W: begin
              state_d = S_WGT;
              cnt_d   = '0;
            end
            OP_LOAD_A: begin
              state_d = S_ACT;
              cnt_d   = '0;
            end
            OP_START: state_d = S_START;
            OP_WF_RST: begin
              wf_reset_d = 1'b1;
              wready_d   = 1'b0;
            end
            OP_CLR_ERR: begin
              err_op_d = 1'b0;
              err_to_d = 1'b0;
            end
            default: err_op_d = 1'b1;
          endcase
        end
      end

      S_WGT: begin
        if (rx_fire) begin
          wf_data_d = rx_data;
          // First half of the payload feeds column 0, second half column 1.
          if (cnt_q < CNT_W'(2)) begin
            push0_d = 1'b1;
          end else begin
            push1_d = 1'b1;
          end
          if (cnt_q == WGT_LAST) begin
            wready_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_CMD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_ACT: begin
        if (rx_fire) begin
          if (!cnt_q[0]) begin
            act_lo_d = rx_data;
          end else begin
            act_valid_d = 1'b1;
            act_data_d  = {rx_data, act_lo_q};
          end
          if (cnt_q == ACT_LAST) begin
            cnt_d   = '0;
            state_d = S_CMD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_START: begin
        start_d  = 1'b1;
        wready_d = 1'b0;
        timer_d  = '0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        // A completion edge in the final timer cycle still counts as success.
        if (lc_rise) begin
          ser_load = 1'b1;
          state_d  = S_SEND;
        end else if (timer_q == TMO_LAST) begin
          err_to_d = 1'b1;
          state_d  = S_CMD;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_SEND: begin
        if (ser_last) begin
          state_d = S_CMD;
        end
      end

      default: state_d = S_CMD;
    endcase
  end

  // rx_ready and busy are registered from the next state so they line up with
  // state_q in every cycle after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q          <= '0;
      timer_q        <= '0;
      act_lo_q       <= '0;
      lc_q           <= 1'b0;
      rx_ready       <= 1'b0;
      busy           <= 1'b0;
      wf_push_col0   <= 1'b0;
      wf_push_col1   <= 1'b0;
      wf_data_out    <= '0;
      wf_reset       <= 1'b0;
      init_act_valid <= 1'b0;
      init_act_data  <= '0;
      start_mlp      <= 1'b0;
      weights_ready  <= 1'b0;
      err_opcode     <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      timer_q        <= timer_d;
      act_lo_q       <= act_lo_d;
      lc_q           <= layer_complete;
      rx_ready       <= state_accepts_rx(state_d);
      busy           <= (state_d != S_CMD);
      wf_push_col0   <= push0_d;
      wf_push_col1   <= push1_d;
      wf_data_out    <= wf_data_d;
      wf_reset       <= wf_reset_d;
      init_act_valid <= act_valid_d;
      init_act_data  <= act_data_d;
      start_mlp      <= start_d;
      weights_ready  <= wready_d;
      err_opcode     <= err_op_d;
      err_timeout    <= err_to_d;
    end
  end

endmodule

// File: tb/tb_mlp_cmd_loader.sv
// tb/tb_mlp_cmd_loader.sv - scoreboard bench for mlp_cmd_loader
module tb_mlp_cmd_loader;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        wf_push_col0, wf_push_col1, wf_reset;
  logic [7:0]  wf_data_out;
  logic        init_act_valid;
  logic [15:0] init_act_data;
  logic        start_mlp, weights_ready, busy, err_opcode, err_timeout;
  logic        layer_complete = 1'b0;
  logic [31:0] acc0 = 32'h0;
  logic [31:0] acc1 = 32'h0;

  always #5 clk = ~clk;

  mlp_cmd_loader #(.N_ACT_WORDS(2), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .wf_push_col0(wf_push_col0), .wf_push_col1(wf_push_col1), .wf_data_out(wf_data_out),
    .wf_reset(wf_reset), .init_act_valid(init_act_valid), .init_act_data(init_act_data),
    .start_mlp(start_mlp), .weights_ready(weights_ready),
    .layer_complete(layer_complete), .acc0(acc0), .acc1(acc1),
    .busy(busy), .err_opcode(err_opcode), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic       col;
    logic [7:0] data;
  } wf_ev_t;

  wf_ev_t      exp_wf[$];
  logic [15:0] exp_act[$];
  logic [7:0]  exp_tx[$];
  wf_ev_t      mon_wf;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h required=none_pending", nm, act);
  endtask

  // Monitor: every strobe/transfer the DUT presents is matched against the
  // scoreboard queues filled by the stimulus.
  always @(negedge clk) begin
    if (wf_push_col0 || wf_push_col1) begin
      if (exp_wf.size() == 0) unexpected("wf_push", {wf_push_col1, wf_push_col0, wf_data_out});
      else begin
        mon_wf = exp_wf.pop_front();
        chk("wf_col", {wf_push_col1, wf_push_col0}, mon_wf.col ? 2'b10 : 2'b01);
        chk("wf_data", wf_data_out, mon_wf.data);
      end
    end
    if (init_act_valid) begin
      if (exp_act.size() == 0) unexpected("act_word", init_act_data);
      else chk("act_data", init_act_data, exp_act.pop_front());
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) unexpected("tx_byte", tx_data);
      else chk("tx_data", tx_data, exp_tx.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) unexpected("rx_ready_timeout", b);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!start_mlp && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", start_mlp, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic push_wf(input logic col, input logic [7:0] d);
    wf_ev_t e;
    e.col  = col;
    e.data = d;
    exp_wf.push_back(e);
  endtask

  task automatic push_tx(input logic [31:0] a0, input logic [31:0] a1);
    logic [63:0] w;
    w = {a1, a0};
    for (int i = 0; i < 8; i++) exp_tx.push_back(w[8*i +: 8]);
  endtask

  initial begin
    int n;
    logic [7:0] wbytes [4];
    logic [7:0] abytes [4];

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_flags", {rx_ready, tx_valid, busy, weights_ready, err_opcode, err_timeout, start_mlp}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_rx_ready", rx_ready, 1);
    chk("idle_busy", busy, 0);

    // 1: weight load
    wbytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) push_wf(i >= 2, wbytes[i]);
    send_byte(8'h01);
    chk("busy_in_wgt", busy, 1);
    for (int i = 0; i < 4; i++) send_byte(wbytes[i]);
    chk("weights_ready_set", weights_ready, 1);
    chk("wgt_back_to_cmd", busy, 0);

    // 2: activation load
    abytes = '{8'h05, 8'h06, 8'h07, 8'h08};
    exp_act.push_back(16'h0605);
    exp_act.push_back(16'h0807);
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(abytes[i]);
    chk("act_back_to_cmd", busy, 0);

    // 3: start, completion after ~12 cycles, free-running send
    acc0 = 32'h0000_0102;
    acc1 = 32'hFFFF_FFFE;
    push_tx(acc0, acc1);
    send_byte(8'h03);
    chk("rx_ready_low_start", rx_ready, 0);
    wait_start();
    chk("start_clears_wready", weights_ready, 0);
    @(negedge clk);
    chk("start_one_cycle", start_mlp, 0);
    chk("busy_in_wait", busy, 1);
    repeat (10) @(negedge clk);
    layer_complete = 1'b1;
    wait_idle("send3_done");
    chk("send3_tx_drained", exp_tx.size(), 0);

    // 4: level already high on entry is ignored; fresh rise at the last timer
    //    cycle still captures; stall mid-send.
    acc0 = 32'hDEAD_BEEF;
    acc1 = 32'hCAFE_F00D;
    push_tx(32'h89AB_CDEF, 32'h0123_4567);
    send_byte(8'h03);
    wait_start();
    repeat (5) @(negedge clk);
    layer_complete = 1'b0;
    repeat (10) @(negedge clk);
    acc0 = 32'h89AB_CDEF;
    acc1 = 32'h0123_4567;
    layer_complete = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (exp_tx.size() > 4 && n < 50);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_tx_valid", tx_valid, 1);
      chk("stall_tx_data", tx_data, 8'h67);
    end
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_idle("send4_done");
    chk("send4_tx_drained", exp_tx.size(), 0);
    chk("boundary_no_timeout", err_timeout, 0);
    layer_complete = 1'b0;

    // 5: timeout
    send_byte(8'h03);
    wait_start();
    n = 0;
    while (!err_timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_busy", busy, 0);
    chk("timeout_no_tx", tx_valid, 0);
    send_byte(8'h05);
    chk("clr_err_timeout", err_timeout, 0);

    // 6: bad opcode, then reset in the middle of a weight payload
    send_byte(8'h7F);
    chk("err_opcode_set", err_opcode, 1);
    chk("bad_op_stays_cmd", busy, 0);
    push_wf(1'b0, 8'hAA);
    push_wf(1'b0, 8'hBB);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_flags", {rx_ready, tx_valid, busy, weights_ready, err_opcode, err_timeout,
                              wf_push_col0, wf_push_col1, wf_reset, init_act_valid, start_mlp}, 0);
    chk("async_reset_data", {wf_data_out, init_act_data, tx_data}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wbytes = '{8'h10, 8'h20, 8'h30, 8'h40};
    for (int i = 0; i < 4; i++) push_wf(i >= 2, wbytes[i]);
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(wbytes[i]);
    chk("reload_weights_ready", weights_ready, 1);
    chk("reset_cleared_err", err_opcode, 0);

    // WF_RST pulses the FIFO clear and drops weights_ready
    send_byte(8'h04);
    chk("wf_reset_pulse", wf_reset, 1);
    chk("wf_rst_clears_wready", weights_ready, 0);
    @(negedge clk);
    chk("wf_reset_one_cycle", wf_reset, 0);

    repeat (3) @(negedge clk);
    chk("wf_queue_empty", exp_wf.size(), 0);
    chk("act_queue_empty", exp_act.size(), 0);
    chk("tx_queue_empty", exp_tx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
